cvxif_dot4_copro: RTL
=====================

Name: cvxif_dot4_copro

Overview:
- CV-X-IF responder (coprocessor side) for the CVA6 softcore, which runs with the CV-X-IF issuer port enabled. Accelerates MNIST inner loops with a packed signed int8 4-lane dot-product into a private accumulator.
- Sits beside the core on the same clock. Connects to the issue, commit and result channels.
- One instruction in flight at a time. Nothing executes until the core commits it.

Parameters:
- XLEN, 32, register/operand width.
- X_ID_WIDTH, 4, instruction id width on the CV-X-IF channels.
- ACC_WIDTH, 32, accumulator width; must be ≤ XLEN.
- CUSTOM_OPCODE, 7'b0001011, custom-0 major opcode claimed by this block.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- issue_valid_i  in  1  issue request valid
- issue_ready_o  out  1  block can take an issue request
- issue_instr_i  in  32  raw instruction word
- issue_id_i  in  X_ID_WIDTH  instruction id
- issue_rs1_i  in  XLEN  rs1 operand
- issue_rs2_i  in  XLEN  rs2 operand
- issue_accept_o  out  1  instruction claimed (valid during the issue handshake)
- issue_writeback_o  out  1  claimed instruction writes rd
- commit_valid_i  in  1  commit strobe
- commit_id_i  in  X_ID_WIDTH  id being committed or killed
- commit_kill_i  in  1  1 = discard the instruction
- result_valid_o  out  1  result available
- result_ready_i  in  1  core consumes the result
- result_id_o  out  X_ID_WIDTH  id of the result
- result_data_o  out  XLEN  rd write data
- result_rd_o  out  5  destination register
- result_we_o  out  1  write enable for rd

Behaviour:
- Decode: claimed iff opcode == CUSTOM_OPCODE, funct7 == 0 and funct3 is one of:
  - 000 DOT4: acc += Σ signed(rs1[8i+7:8i]) × signed(rs2[8i+7:8i]), i = 0..3; rd ← new acc.
  - 001 CLRACC: rd ← old acc; acc ← 0.
  - 010 RDACC: rd ← acc.
  - 011 SETACC: acc ← rs1[ACC_WIDTH-1:0]; rd ← old acc.
- Unclaimed instructions: accept = 0, writeback = 0, handshake still completes, no state change. Every claimed op has writeback = 1.
- Arithmetic:
  - Each product is 16-bit signed; the sum is 18-bit signed, sign-extended to ACC_WIDTH.
  - Accumulation wraps modulo 2^ACC_WIDTH.
  - rd data is the accumulator sign-extended to XLEN.
- FSM states and transitions:
  - IDLE: issue_ready_o = 1. A claimed handshake latches op, id, rs1, rs2 and rd, then goes to WAIT_COMMIT.
  - WAIT_COMMIT: issue_ready_o = 0. commit_valid_i with commit_id_i == latched id:
    - kill = 1 → IDLE; no result, acc unchanged.
    - kill = 0 → EXEC1.
    - Commits for other ids are ignored.
  - EXEC1: register the 4 products.
  - EXEC2: sum the products, update acc, register the result → RESP.
  - RESP: result_valid_o = 1. Id, data, rd and we are held stable until result_ready_i; then → IDLE.
- Same-cycle cases:
  - A matching commit in the same cycle as the claimed issue handshake is honoured: go straight to EXEC1, or to IDLE on kill.
  - An issue request arriving while RESP completes is not accepted that cycle; ready rises the next cycle.
- Latency: commit → result_valid_o = 3 cycles. Best-case throughput: 1 instruction per 5 cycles.
- Accumulator update happens in EXEC2 only, so a killed instruction never alters acc.
- Reset (async assert, any state including mid-EXEC): state = IDLE, acc = 0, latched fields = 0, every output = 0 except issue_ready_o. issue_ready_o is 0 while rst_ni = 0 and 1 from the first cycle after release.

Decomposition:
- Package cvxif_dot4_pkg holds:
  - typedef op_e {DOT4, CLRACC, RDACC, SETACC};
  - FSM state typedef;
  - funct3/funct7 constants.
- One sub-module, dot4_int8: registered 4-lane signed multiplier plus a combinational adder tree producing an 18-bit sum. Used across EXEC1/EXEC2.

Test Plan:
- DOT4 rs1=0x01020304, rs2=0x01010101 from acc=0, commit kill=0 → result 0x0000000A three cycles after commit; second identical op → 0x00000014.
- DOT4 rs1=0xFFFFFFFF, rs2=0x02020202 with acc=0x0A → result 0x00000002. SETACC rs1=0x7FFFFFFF then DOT4 rs1=rs2=0x00000001 → result 0x80000000 (wrap).
- Claimed DOT4 followed by commit kill=1 for its id → no result_valid_o; RDACC then returns the unchanged acc.
- Hold result_ready_i = 0 for 5 cycles in RESP → outputs stable and issue_ready_o = 0 throughout; release → one transfer, then IDLE.
- funct3=111 or a foreign opcode → accept = 0, issue_ready_o stays 1, acc unchanged. Commit with a mismatched id in WAIT_COMMIT → ignored.
- Assert rst_ni during EXEC2 → all outputs 0 immediately and acc reads 0 via RDACC after release. Same-cycle issue+commit → result valid 3 cycles later.

Source files
------------

// File: rtl/cvxif_dot4_pkg.sv
// rtl/cvxif_dot4_pkg.sv - shared types and decode constants for the CV-X-IF dot4 coprocessor
package cvxif_dot4_pkg;

  localparam logic [6:0] FUNCT7_CUSTOM = 7'b0000000;
  localparam logic [2:0] F3_DOT4       = 3'b000;
  localparam logic [2:0] F3_CLRACC     = 3'b001;
  localparam logic [2:0] F3_RDACC      = 3'b010;
  localparam logic [2:0] F3_SETACC     = 3'b011;

  // Encoding matches funct3[1:0] so decode is a direct cast
  typedef enum logic [1:0] {
    DOT4   = 2'd0,
    CLRACC = 2'd1,
    RDACC  = 2'd2,
    SETACC = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_COMMIT,
    S_EXEC1,
    S_EXEC2,
    S_RESP
  } state_e;

  // Only the lower half of the funct3 space is claimed
  function automatic logic f3_claimed(input logic [2:0] f3);
    return (f3[2] == 1'b0);
  endfunction

endpackage

// File: rtl/dot4_int8.sv
// rtl/dot4_int8.sv - registered 4-lane signed int8 multiplier with combinational 18-bit adder tree
module dot4_int8 (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               i_en,
  input  logic [31:0]        i_a,
  input  logic [31:0]        i_b,
  output logic signed [17:0] o_sum
);

  logic signed [15:0] w_prod [4];
  logic signed [15:0] r_prod [4];

  // Lane products; 16 bits hold every int8 x int8 result exactly
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      w_prod[i] = $signed({{8{i_a[8*i+7]}}, i_a[8*i +: 8]}) *
                  $signed({{8{i_b[8*i+7]}}, i_b[8*i +: 8]});
    end
  end

  // Capture the products when the controller is in its first execute cycle
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < 4; i++) r_prod[i] <= '0;
    end else if (i_en) begin
      for (int i = 0; i < 4; i++) r_prod[i] <= w_prod[i];
    end
  end

  // Sign-extended sum; 4 x 16384 still fits in 18 signed bits
  always_comb begin
    o_sum = '0;
    for (int i = 0; i < 4; i++) begin
      o_sum = o_sum + $signed({{2{r_prod[i][15]}}, r_prod[i]});
    end
  end

endmodule

// File: rtl/cvxif_dot4_copro.sv
// rtl/cvxif_dot4_copro.sv - CV-X-IF responder executing packed int8 dot4 into a private accumulator
module cvxif_dot4_copro
  import cvxif_dot4_pkg::*;
#(
  parameter int         XLEN          = 32,
  parameter int         X_ID_WIDTH    = 4,
  parameter int         ACC_WIDTH     = 32,
  parameter logic [6:0] CUSTOM_OPCODE = 7'b0001011
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  issue_valid_i,
  output logic                  issue_ready_o,
  input  logic [31:0]           issue_instr_i,
  input  logic [X_ID_WIDTH-1:0] issue_id_i,
  input  logic [XLEN-1:0]       issue_rs1_i,
  input  logic [XLEN-1:0]       issue_rs2_i,
  output logic                  issue_accept_o,
  output logic                  issue_writeback_o,
  input  logic                  commit_valid_i,
  input  logic [X_ID_WIDTH-1:0] commit_id_i,
  input  logic                  commit_kill_i,
  output logic                  result_valid_o,
  input  logic                  result_ready_i,
  output logic [X_ID_WIDTH-1:0] result_id_o,
  output logic [XLEN-1:0]       result_data_o,
  output logic [4:0]            result_rd_o,
  output logic                  result_we_o
);

  state_e                r_state;
  op_e                   r_op;
  logic [X_ID_WIDTH-1:0] r_id;
  logic [XLEN-1:0]       r_rs1;
  logic [XLEN-1:0]       r_rs2;
  logic [4:0]            r_rd;
  logic [ACC_WIDTH-1:0]  r_acc;
  logic                  r_issue_ready;
  logic                  r_result_valid;
  logic [X_ID_WIDTH-1:0] r_result_id;
  logic [XLEN-1:0]       r_result_data;
  logic [4:0]            r_result_rd;
  logic                  r_result_we;

  logic                  w_claim;
  logic                  w_handshake;
  logic                  w_issue_commit;
  logic                  w_commit_match;
  logic signed [17:0]    w_sum;
  logic [ACC_WIDTH-1:0]  w_acc_next;
  logic [ACC_WIDTH-1:0]  w_rd_acc;
  logic                  w_unused_instr;

  assign w_claim        = (issue_instr_i[6:0] == CUSTOM_OPCODE) &&
                          (issue_instr_i[31:25] == FUNCT7_CUSTOM) &&
                          f3_claimed(issue_instr_i[14:12]);
  assign w_handshake    = issue_valid_i && r_issue_ready;
  assign w_issue_commit = commit_valid_i && (commit_id_i == issue_id_i);
  assign w_commit_match = commit_valid_i && (commit_id_i == r_id);
  assign w_unused_instr = ^issue_instr_i[24:15];

  assign issue_ready_o     = r_issue_ready;
  assign issue_accept_o    = w_handshake && w_claim;
  assign issue_writeback_o = w_handshake && w_claim;
  assign result_valid_o    = r_result_valid;
  assign result_id_o       = r_result_id;
  assign result_data_o     = r_result_data;
  assign result_rd_o       = r_rd_out();
  assign result_we_o       = r_result_we;

  function automatic logic [4:0] r_rd_out();
    return r_result_rd;
  endfunction

  dot4_int8 u_dot4 (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .i_en   (r_state == S_EXEC1),
    .i_a    (r_rs1[31:0]),
    .i_b    (r_rs2[31:0]),
    .o_sum  (w_sum)
  );

  // Next accumulator value and the value returned in rd for the latched op
  always_comb begin
    w_acc_next = r_acc;
    w_rd_acc   = r_acc;
    case (r_op)
      DOT4: begin
        w_acc_next = r_acc + ACC_WIDTH'(w_sum);
        w_rd_acc   = w_acc_next;
      end
      CLRACC: w_acc_next = '0;
      RDACC:  w_acc_next = r_acc;
      SETACC: w_acc_next = r_rs1[ACC_WIDTH-1:0];
      default: w_acc_next = r_acc;
    endcase
  end

  // Control FSM with registered outputs; acc only changes in EXEC2
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state        <= S_IDLE;
      r_op           <= DOT4;
      r_id           <= '0;
      r_rs1          <= '0;
      r_rs2          <= '0;
      r_rd           <= '0;
      r_acc          <= '0;
      r_issue_ready  <= 1'b0;
      r_result_valid <= 1'b0;
      r_result_id    <= '0;
      r_result_data  <= '0;
      r_result_rd    <= '0;
      r_result_we    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_issue_ready <= 1'b1;
          if (w_handshake && w_claim) begin
            r_op  <= op_e'(issue_instr_i[13:12]);
            r_id  <= issue_id_i;
            r_rs1 <= issue_rs1_i;
            r_rs2 <= issue_rs2_i;
            r_rd  <= issue_instr_i[11:7];
            if (w_issue_commit && commit_kill_i) begin
              r_state <= S_IDLE;
            end else if (w_issue_commit) begin
              r_state       <= S_EXEC1;
              r_issue_ready <= 1'b0;
            end else begin
              r_state       <= S_WAIT_COMMIT;
              r_issue_ready <= 1'b0;
            end
          end
        end
        S_WAIT_COMMIT: begin
          if (w_commit_match) begin
            r_state       <= commit_kill_i ? S_IDLE : S_EXEC1;
            r_issue_ready <= commit_kill_i;
          end
        end
        S_EXEC1: r_state <= S_EXEC2;
        S_EXEC2: begin
          r_acc          <= w_acc_next;
          r_result_valid <= 1'b1;
          r_result_id    <= r_id;
          r_result_data  <= XLEN'($signed(w_rd_acc));
          r_result_rd    <= r_rd;
          r_result_we    <= 1'b1;
          r_state        <= S_RESP;
        end
        S_RESP: begin
          if (result_ready_i) begin
            r_result_valid <= 1'b0;
            r_issue_ready  <= 1'b1;
            r_state        <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
